uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- Transmit controller sitting between two byte producers (req0 = CPU memory-mapped UART store, req1 = debug/monitor port) and the existing 8N1 serializer `tx`.
- Arbitrates both producers round-robin into a shared sync FIFO.
- Generates the baud `tick` for the serializer.
- Sequences serializer frames through its `wr_en`/`txBusy` handshake, one byte at a time.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (tick period); must be >= 2.
- FIFO_DEPTH, 8, byte entries in shared FIFO; power of two, >= 2.
- BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after wr_en before flagging error.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  CPU has a byte.
- req0_data  in  8  CPU byte.
- req0_ready  out  1  CPU byte accepted this cycle.
- req1_valid  in  1  debug port has a byte.
- req1_data  in  8  debug byte.
- req1_ready  out  1  debug byte accepted this cycle.
- tx_data  out  8  byte to serializer dados_transmissao.
- tx_wr_en  out  1  one-cycle load strobe to serializer.
- tx_busy  in  1  serializer txBusy.
- tick  out  1  one-cycle baud pulse to serializer.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_done  out  1  one-cycle pulse when a frame completes.
- err  out  1  sticky; serializer failed to go busy; cleared only by rst.

Behaviour:
- Reset values: tx_data=0, tx_wr_en=0, tick=0, frame_done=0, err=0, fifo_count=0.
- Reset effects: FIFO emptied, baud counter=0, RR pointer favours req0, state=IDLE.
- Baud tick: free-running counter 0..CLKS_PER_BIT-1, wraps to 0. tick is registered and high for the single cycle in which the counter equals CLKS_PER_BIT-1. With CLKS_PER_BIT=4 the first tick is at cycle 4 after reset release, then every 4 cycles.
- Arbitration (combinational grant, same-cycle acceptance):
  - Push is allowed only if fifo_count < FIFO_DEPTH, using the current count; a same-cycle pop does not free a slot.
  - Only one valid: grant it. Both valid: grant the requester not granted last; RR pointer updates only on a grant.
  - reqN_ready = grant to N; at most one ready per cycle; both 0 when full.
  - Data is written at the clock edge where valid && ready.
- FIFO: registered push and pop; simultaneous push and pop leaves count unchanged. Pop of the head happens only on the IDLE->LOAD transition. No overflow or underflow is possible by construction.
- Sequencer FSM:
  - IDLE: if fifo_count>0 && !tx_busy -> LOAD. On that edge, tx_data<=head, pop, tx_wr_en<=1.
  - LOAD (1 cycle, tx_wr_en=1): -> WAIT_BUSY; tx_wr_en<=0. The serializer samples the strobe in this cycle.
  - WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Otherwise count; after BUSY_TIMEOUT cycles, err<=1 and -> IDLE (the byte is dropped).
  - WAIT_DONE: tx_busy=0 -> IDLE with frame_done pulsed for 1 cycle.
  - Undefined encoding -> IDLE.
- tx_data holds its value until the next LOAD.
- Reset mid-frame: the serializer has no reset and finishes its frame. The controller restarts in IDLE, and its !tx_busy guard blocks a new load until that frame ends. tick keeps running after reset so the frame can drain.
- Back-to-back frames: minimum 1 IDLE cycle between frame_done and the next tx_wr_en.
- fifo_count width covers the full value FIFO_DEPTH.

Decomposition:
- parameters.v gains `CTRL_IDLE, `CTRL_LOAD, `CTRL_WAIT_BUSY, `CTRL_WAIT_DONE as 2-bit state constants, alongside the existing stage defines.
- One natural sub-module: tx_fifo, a parameterised sync FIFO with push, pop, head, count, full and empty.
- Baud counter, arbiter and FSM stay in uart_tx_ctrl.
- Bench top instantiates uart_tx_ctrl with the real tx serializer.

Test Plan:
- Tick: CLKS_PER_BIT=4, release rst -> tick high at cycles 4, 8, 12, each exactly 1 cycle wide. Assert rst mid-count -> counter restarts and next tick is 4 cycles after release.
- Single byte: req0 pushes 0xA5 -> req0_ready=1 that cycle, fifo_count 1 then 0 on pop, tx_wr_en one cycle with tx_data=0xA5. Serial line carries 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1. frame_done pulses once.
- Contention: req0 and req1 both valid every cycle with bytes 0x10.. and 0x80.. -> grants alternate req0, req1, req0, …; serializer output order is 0x10, 0x80, 0x11, 0x81.
- Full FIFO: FIFO_DEPTH=8, tx_busy held 1 by a stub, push 9 bytes -> fifo_count=8, both readies 0, 9th byte held at source until a pop. Push+pop in one cycle -> count unchanged.
- Timeout: stub serializer never raises tx_busy, one byte queued -> after LOAD plus BUSY_TIMEOUT=4 cycles err=1 and stays 1, FSM in IDLE, next byte still loads.
- Reset mid-frame: rst for 1 cycle while serializer in its data stage with 3 bytes queued -> fifo_count=0, tx_wr_en stays 0 until tx_busy falls, serializer completes the old frame cleanly, and no spurious load follows.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types for the UART transmit controller:
// sequencer state encoding and the round-robin pick helper.
package uart_tx_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        CTRL_IDLE      = 2'd0,
        CTRL_LOAD      = 2'd1,
        CTRL_WAIT_BUSY = 2'd2,
        CTRL_WAIT_DONE = 2'd3
    } ctrl_state_t;

    // req1 wins when it is alone or when it is its turn
    function automatic logic rr_pick1(
        input logic v0,
        input logic v1,
        input logic prio1
    );
        return v1 && (!v0 || prio1);
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// Parameterised synchronous FIFO feeding the transmit sequencer.
// Registered push/pop; count spans 0..DEPTH inclusive.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: round-robin byte intake, shared FIFO,
// baud tick generation and frame sequencing toward the 8N1 serializer.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    input  logic [7:0]                    req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [7:0]                    req1_data,
    output logic                          req1_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_wr_en,
    input  logic                          tx_busy,
    output logic                          tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_done,
    output logic                          err
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(BUSY_TIMEOUT - 1);

    logic [BW-1:0]     r_baud_cnt;
    logic              r_prio1;
    logic [TW-1:0]     r_to_cnt;
    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_push;
    logic [BYTE_W-1:0] w_push_data;
    logic [BYTE_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_load;
    logic              w_timeout;
    logic              w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= '0;
            tick       <= 1'b0;
        end else begin
            tick       <= (r_baud_cnt == BAUD_MAX);
            r_baud_cnt <= (r_baud_cnt == BAUD_MAX) ? '0 : r_baud_cnt + 1'b1;
        end
    end

    // grant uses the count before any same-cycle pop
    always_comb begin
        w_gnt1 = !w_full && rr_pick1(req0_valid, req1_valid, r_prio1);
        w_gnt0 = !w_full && req0_valid && !w_gnt1;
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign w_push      = w_gnt0 || w_gnt1;
    assign w_push_data = w_gnt1 ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio1 <= 1'b0;
        end else if (w_gnt0) begin
            r_prio1 <= 1'b1;
        end else if (w_gnt1) begin
            r_prio1 <= 1'b0;
        end
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_load),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CTRL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // !tx_busy in IDLE also holds off a load while a pre-reset frame drains
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            CTRL_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_load      = 1'b1;
                    w_state_nxt = CTRL_LOAD;
                end
            end
            CTRL_LOAD: begin
                w_state_nxt = CTRL_WAIT_BUSY;
            end
            CTRL_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = CTRL_WAIT_DONE;
                end else if (r_to_cnt == TO_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = CTRL_IDLE;
                end
            end
            CTRL_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = CTRL_IDLE;
                end
            end
            default: begin
                w_state_nxt = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data    <= '0;
            tx_wr_en   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            tx_wr_en   <= w_load;
            frame_done <= w_done;
            if (w_load) begin
                tx_data <= w_head;
            end
            if (w_timeout) begin
                err <= 1'b1;
            end
            if (r_state != CTRL_WAIT_BUSY) begin
                r_to_cnt <= '0;
            end else if (!tx_busy) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule
